// File: rtl/conv_idx_addr_gen.sv
// Turns the layer controller's one-hot phase flags into image/conv/pool memory addresses and strobes,
// and owns the local_idx/row_idx counters the controller watches. All outputs are registered (1-cycle latency).
module conv_idx_addr_gen #(
  parameter int LOCAL_IDX_WIDTH  = 16,
  parameter int IMG_W_LOG2       = 6,
  parameter int F_GEN_IN_ADDR    = 0,
  parameter int F_READ_IN_ENB    = 1,
  parameter int F_CONV_RELU_ENB  = 2,
  parameter int F_WRITE_CONV_ENB = 3,
  parameter int F_GEN_CONV_ADDR  = 4,
  parameter int F_READ_CONV_ENB  = 5,
  parameter int F_WRITE_POOL_ENB = 6,
  parameter int F_WRITE_FLAT_ENB = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [11:0]                flags,
  input  logic                       local_idx_rst,
  input  logic                       row_idx_rst,
  output logic [LOCAL_IDX_WIDTH-1:0] local_idx,
  output logic [7:0]                 row_idx,
  output logic [2*IMG_W_LOG2-1:0]    iaddr,
  output logic                       ipad,
  output logic [2*IMG_W_LOG2-1:0]    caddr_wr,
  output logic                       cwr,
  output logic [2*IMG_W_LOG2-1:0]    caddr_rd,
  output logic                       crd,
  output logic [1:0]                 csel
);

  localparam int CW = IMG_W_LOG2;      // coordinate width
  localparam int AW = 2 * IMG_W_LOG2;  // full image address width
  localparam int PW = AW - 2;          // pooled-map address width

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_IN_ADDR,
    PH_PASSIVE,
    PH_CONV_WR,
    PH_POOL_RD,
    PH_POOL_WR,
    PH_FLAT_WR
  } phase_t;

  phase_t        phase;
  logic [AW-1:0] in_ptr;
  logic [3:0]    tap;
  logic [AW:0]   conv_ptr;
  logic [PW-1:0] pool_ptr;
  logic [1:0]    quad;
  logic [PW-1:0] wr_ptr;
  logic [1:0]    dx, dy;
  logic [3:0]    tap_rem;
  logic [CW:0]   x, y;
  logic          any_flag;
  logic          unused_flags;

  assign unused_flags = ^flags[11:8];
  assign any_flag     = |flags[7:0];
  assign row_idx      = 8'(conv_ptr >> CW);

  // Lowest set bit wins; the legal pairs fall out naturally because the
  // address-generating flag of each pair is the lower bit.
  always_comb begin
    phase = PH_IDLE;
    if (flags[F_GEN_IN_ADDR])         phase = PH_IN_ADDR;
    else if (flags[F_READ_IN_ENB])    phase = PH_PASSIVE;
    else if (flags[F_CONV_RELU_ENB])  phase = PH_PASSIVE;
    else if (flags[F_WRITE_CONV_ENB]) phase = PH_CONV_WR;
    else if (flags[F_GEN_CONV_ADDR])  phase = PH_POOL_RD;
    else if (flags[F_READ_CONV_ENB])  phase = PH_POOL_RD;
    else if (flags[F_WRITE_POOL_ENB]) phase = PH_POOL_WR;
    else if (flags[F_WRITE_FLAT_ENB]) phase = PH_FLAT_WR;
  end

  // 3x3 tap offsets; coordinates carry one extra bit so -1 and IMG_W both
  // land with the top bit set, which is exactly the padding condition.
  always_comb begin
    dy = 2'd0;
    if (tap >= 4'd6)      dy = 2'd2;
    else if (tap >= 4'd3) dy = 2'd1;
    tap_rem = tap - {1'b0, dy, 1'b0} - {2'b00, dy};
    dx      = tap_rem[1:0];
    x = {1'b0, in_ptr[CW-1:0]}  + (CW+1)'(dx) - (CW+1)'(1);
    y = {1'b0, in_ptr[AW-1:CW]} + (CW+1)'(dy) - (CW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      local_idx <= '0;
      in_ptr    <= '0;
      tap       <= '0;
      conv_ptr  <= '0;
      pool_ptr  <= '0;
      quad      <= '0;
      wr_ptr    <= '0;
      iaddr     <= '0;
      ipad      <= 1'b0;
      caddr_wr  <= '0;
      cwr       <= 1'b0;
      caddr_rd  <= '0;
      crd       <= 1'b0;
      csel      <= 2'd0;
    end else begin
      if (row_idx_rst || local_idx_rst)
        local_idx <= '0;
      else if (any_flag && !(&local_idx))
        local_idx <= local_idx + LOCAL_IDX_WIDTH'(1);

      cwr  <= 1'b0;
      crd  <= 1'b0;
      csel <= 2'd0;
      ipad <= 1'b0;

      if (row_idx_rst) begin
        in_ptr   <= '0;
        tap      <= '0;
        conv_ptr <= '0;
        pool_ptr <= '0;
        quad     <= '0;
        wr_ptr   <= '0;
      end else begin
        if (local_idx_rst)
          wr_ptr <= '0;

        case (phase)
          PH_IN_ADDR: begin
            iaddr <= {y[CW-1:0], x[CW-1:0]};
            ipad  <= x[CW] | y[CW];
            if (tap == 4'd8) begin
              tap    <= '0;
              in_ptr <= in_ptr + AW'(1);
            end else begin
              tap <= tap + 4'd1;
            end
          end
          PH_CONV_WR: begin
            if (!conv_ptr[AW]) begin
              cwr      <= 1'b1;
              csel     <= 2'd1;
              caddr_wr <= conv_ptr[AW-1:0];
              conv_ptr <= conv_ptr + (AW+1)'(1);
            end
          end
          PH_POOL_RD: begin
            caddr_rd <= {pool_ptr[PW-1:CW-1], quad[1], pool_ptr[CW-2:0], quad[0]};
            crd      <= flags[F_READ_CONV_ENB];
            csel     <= flags[F_READ_CONV_ENB] ? 2'd1 : 2'd0;
            quad     <= quad + 2'd1;
            if (quad == 2'd3 && !(&pool_ptr))
              pool_ptr <= pool_ptr + PW'(1);
          end
          PH_POOL_WR, PH_FLAT_WR: begin
            cwr      <= 1'b1;
            csel     <= (phase == PH_POOL_WR) ? 2'd2 : 2'd3;
            caddr_wr <= {2'b00, wr_ptr};
            if (!local_idx_rst)
              wr_ptr <= wr_ptr + PW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_idx_addr_gen.sv
// Directed bench for conv_idx_addr_gen: inputs change 1ns after posedge, outputs sampled there too.
module tb_conv_idx_addr_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] flags = 12'h000;
  logic        local_idx_rst = 1'b0;
  logic        row_idx_rst = 1'b0;
  logic [15:0] local_idx;
  logic [7:0]  row_idx;
  logic [11:0] iaddr;
  logic        ipad;
  logic [11:0] caddr_wr;
  logic        cwr;
  logic [11:0] caddr_rd;
  logic        crd;
  logic [1:0]  csel;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_ia  [9] = '{12'hFFF, 12'hFC0, 12'hFC1, 12'h03F, 12'h000,
                               12'h001, 12'h07F, 12'h040, 12'h041};
  logic        exp_pad [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [11:0] exp_rd  [8] = '{12'd0, 12'd1, 12'd64, 12'd65, 12'd2, 12'd3, 12'd66, 12'd67};

  conv_idx_addr_gen dut (
    .clk(clk), .reset(reset), .flags(flags),
    .local_idx_rst(local_idx_rst), .row_idx_rst(row_idx_rst),
    .local_idx(local_idx), .row_idx(row_idx),
    .iaddr(iaddr), .ipad(ipad),
    .caddr_wr(caddr_wr), .cwr(cwr),
    .caddr_rd(caddr_rd), .crd(crd), .csel(csel)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_row_rst();
    flags = 12'h000;
    row_idx_rst = 1'b1;
    step();
    row_idx_rst = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    reset = 1'b0;
    repeat (5) step();
    checks++; if (local_idx !== 16'd0) begin errors++; $display("FAIL reset_local_idx: got %0d want 0", local_idx); end
    checks++; if (row_idx !== 8'd0) begin errors++; $display("FAIL reset_row_idx: got %0d want 0", row_idx); end
    checks++; if (cwr !== 1'b0) begin errors++; $display("FAIL reset_cwr: got %b want 0", cwr); end
    checks++; if (crd !== 1'b0) begin errors++; $display("FAIL reset_crd: got %b want 0", crd); end
    checks++; if (csel !== 2'd0) begin errors++; $display("FAIL reset_csel: got %0d want 0", csel); end
    checks++; if (iaddr !== 12'd0) begin errors++; $display("FAIL reset_iaddr: got %h want 000", iaddr); end
    checks++; if (caddr_wr !== 12'd0) begin errors++; $display("FAIL reset_caddr_wr: got %h want 000", caddr_wr); end
  endtask

  task automatic test_input_addr();
    flags = 12'h003;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++; if (iaddr !== exp_ia[i]) begin errors++; $display("FAIL in_iaddr[%0d]: got %h want %h", i, iaddr, exp_ia[i]); end
      checks++; if (ipad !== exp_pad[i]) begin errors++; $display("FAIL in_ipad[%0d]: got %b want %b", i, ipad, exp_pad[i]); end
      checks++; if (cwr !== 1'b0) begin errors++; $display("FAIL in_cwr[%0d]: got %b want 0", i, cwr); end
    end
    // in_ptr is now 1: tap 0 gives x=0, y=-1
    step();
    checks++; if (iaddr !== 12'hFC0) begin errors++; $display("FAIL in_next_ptr: got %h want fc0", iaddr); end
    checks++; if (ipad !== 1'b1) begin errors++; $display("FAIL in_next_pad: got %b want 1", ipad); end
    checks++; if (local_idx !== 16'd10) begin errors++; $display("FAIL in_local_idx: got %0d want 10", local_idx); end
    flags = 12'h000;
    step();
    checks++; if (iaddr !== 12'hFC0) begin errors++; $display("FAIL in_idle_hold: got %h want fc0", iaddr); end
    checks++; if (local_idx !== 16'd10) begin errors++; $display("FAIL in_idle_local: got %0d want 10", local_idx); end
  endtask

  task automatic test_conv_write();
    pulse_row_rst();
    flags = 12'h008;
    for (int i = 0; i < 4096; i++) begin
      step();
      checks++; if (caddr_wr !== 12'(i)) begin errors++; $display("FAIL conv_addr[%0d]: got %0d want %0d", i, caddr_wr, i); end
      checks++; if (cwr !== 1'b1) begin errors++; $display("FAIL conv_cwr[%0d]: got %b want 1", i, cwr); end
      checks++; if (row_idx !== 8'((i + 1) / 64)) begin errors++; $display("FAIL conv_row[%0d]: got %0d want %0d", i, row_idx, (i + 1) / 64); end
      if (i < 64) begin
        checks++; if (csel !== 2'd1) begin errors++; $display("FAIL conv_csel[%0d]: got %0d want 1", i, csel); end
      end
      if (i == 63) begin
        checks++; if (local_idx !== 16'd64) begin errors++; $display("FAIL conv_local_idx: got %0d want 64", local_idx); end
      end
    end
    step();
    checks++; if (cwr !== 1'b0) begin errors++; $display("FAIL conv_sat_cwr: got %b want 0", cwr); end
    checks++; if (row_idx !== 8'd64) begin errors++; $display("FAIL conv_sat_row: got %0d want 64", row_idx); end
    checks++; if (caddr_wr !== 12'd4095) begin errors++; $display("FAIL conv_sat_addr: got %0d want 4095", caddr_wr); end
    flags = 12'h000;
    step();
    checks++; if (csel !== 2'd0) begin errors++; $display("FAIL conv_idle_csel: got %0d want 0", csel); end
  endtask

  task automatic test_pool_read();
    pulse_row_rst();
    checks++; if (row_idx !== 8'd0) begin errors++; $display("FAIL rowrst_row_idx: got %0d want 0", row_idx); end
    checks++; if (local_idx !== 16'd0) begin errors++; $display("FAIL rowrst_local_idx: got %0d want 0", local_idx); end
    flags = 12'h030;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (caddr_rd !== exp_rd[i]) begin errors++; $display("FAIL pool_rd[%0d]: got %0d want %0d", i, caddr_rd, exp_rd[i]); end
      checks++; if (crd !== 1'b1) begin errors++; $display("FAIL pool_crd[%0d]: got %b want 1", i, crd); end
    end
    flags = 12'h010;
    step();
    checks++; if (caddr_rd !== 12'd4) begin errors++; $display("FAIL pool_gen_only_addr: got %0d want 4", caddr_rd); end
    checks++; if (crd !== 1'b0) begin errors++; $display("FAIL pool_gen_only_crd: got %b want 0", crd); end
    flags = 12'h020;
    step();
    checks++; if (caddr_rd !== 12'd5) begin errors++; $display("FAIL pool_read_only_addr: got %0d want 5", caddr_rd); end
    checks++; if (crd !== 1'b1) begin errors++; $display("FAIL pool_read_only_crd: got %b want 1", crd); end
    flags = 12'h000;
    step();
    checks++; if (crd !== 1'b0) begin errors++; $display("FAIL pool_idle_crd: got %b want 0", crd); end
    checks++; if (caddr_rd !== 12'd5) begin errors++; $display("FAIL pool_idle_hold: got %0d want 5", caddr_rd); end
  endtask

  task automatic test_pool_flat_write();
    pulse_row_rst();
    flags = 12'h040;
    for (int i = 0; i < 1024; i++) begin
      step();
      checks++; if (caddr_wr !== 12'(i)) begin errors++; $display("FAIL poolwr_addr[%0d]: got %0d want %0d", i, caddr_wr, i); end
      checks++; if (csel !== 2'd2) begin errors++; $display("FAIL poolwr_csel[%0d]: got %0d want 2", i, csel); end
      checks++; if (cwr !== 1'b1) begin errors++; $display("FAIL poolwr_cwr[%0d]: got %b want 1", i, cwr); end
    end
    flags = 12'h000;
    local_idx_rst = 1'b1;
    step();
    local_idx_rst = 1'b0;
    checks++; if (local_idx !== 16'd0) begin errors++; $display("FAIL lrst_local_idx: got %0d want 0", local_idx); end
    checks++; if (cwr !== 1'b0) begin errors++; $display("FAIL lrst_cwr: got %b want 0", cwr); end
    flags = 12'h080;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (caddr_wr !== 12'(i)) begin errors++; $display("FAIL flatwr_addr[%0d]: got %0d want %0d", i, caddr_wr, i); end
      checks++; if (csel !== 2'd3) begin errors++; $display("FAIL flatwr_csel[%0d]: got %0d want 3", i, csel); end
    end
    flags = 12'h000;
  endtask

  task automatic test_priority_and_reset();
    pulse_row_rst();
    flags = 12'h008;
    repeat (3) step();
    checks++; if (caddr_wr !== 12'd2) begin errors++; $display("FAIL prio_pre_addr: got %0d want 2", caddr_wr); end
    local_idx_rst = 1'b1;
    row_idx_rst = 1'b1;
    step();
    local_idx_rst = 1'b0;
    row_idx_rst = 1'b0;
    checks++; if (local_idx !== 16'd0) begin errors++; $display("FAIL prio_local_idx: got %0d want 0", local_idx); end
    checks++; if (row_idx !== 8'd0) begin errors++; $display("FAIL prio_row_idx: got %0d want 0", row_idx); end
    checks++; if (cwr !== 1'b0) begin errors++; $display("FAIL prio_cwr: got %b want 0", cwr); end
    step();
    checks++; if (caddr_wr !== 12'd0) begin errors++; $display("FAIL prio_no_incr: got %0d want 0", caddr_wr); end
    checks++; if (cwr !== 1'b1) begin errors++; $display("FAIL prio_resume_cwr: got %b want 1", cwr); end
    flags = 12'h048;
    step();
    checks++; if (caddr_wr !== 12'd1) begin errors++; $display("FAIL illegal_addr: got %0d want 1", caddr_wr); end
    checks++; if (csel !== 2'd1) begin errors++; $display("FAIL illegal_csel: got %0d want 1", csel); end
    checks++; if (local_idx !== 16'd2) begin errors++; $display("FAIL illegal_local_idx: got %0d want 2", local_idx); end
    flags = 12'h008;
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (cwr !== 1'b0) begin errors++; $display("FAIL async_cwr: got %b want 0", cwr); end
    checks++; if (caddr_wr !== 12'd0) begin errors++; $display("FAIL async_addr: got %0d want 0", caddr_wr); end
    checks++; if (csel !== 2'd0) begin errors++; $display("FAIL async_csel: got %0d want 0", csel); end
    checks++; if (local_idx !== 16'd0) begin errors++; $display("FAIL async_local_idx: got %0d want 0", local_idx); end
    step();
    reset = 1'b0;
    step();
    checks++; if (caddr_wr !== 12'd0) begin errors++; $display("FAIL after_reset_addr: got %0d want 0", caddr_wr); end
    checks++; if (cwr !== 1'b1) begin errors++; $display("FAIL after_reset_cwr: got %b want 1", cwr); end
    flags = 12'h000;
  endtask

  initial begin
    test_reset();
    test_input_addr();
    test_conv_write();
    test_pool_read();
    test_pool_flat_write();
    test_priority_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
